// File: rtl/dm_pkg.sv
// Shared encodings and lane-steering helpers for the data-memory controller.
package dm_pkg;

    // Access size encodings as presented on the size port.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    // Controller state encodings.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } dm_state_e;

    // True when the size is illegal or the address is not naturally aligned.
    function automatic logic dm_misaligned(input logic [1:0] size, input logic [1:0] a);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = a[0];
            SZ_W:    bad = (a != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte-lane write enables; lane 0 is bits [7:0] (little-endian).
    function automatic logic [3:0] dm_byte_en(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            SZ_B:    be = 4'b0001 << a;
            SZ_H:    be = a[1] ? 4'b1100 : 4'b0011;
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data across the word so the byte
    // enables alone pick the destination lanes.
    function automatic logic [31:0] dm_store_data(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        case (size)
            SZ_B:    w = {4{d[7:0]}};
            SZ_H:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Pull the addressed lane(s) out of a word and sign- or zero-extend.
    function automatic logic [31:0] dm_load_extend(input logic [1:0]  size,
                                                   input logic [1:0]  a,
                                                   input logic        uns,
                                                   input logic [31:0] word);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        shifted = word >> {a, 3'b000};
        b       = shifted[7:0];
        h       = a[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_H:    r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            SZ_W:    r = word;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dm_ram.sv
// Word-organised storage split into four byte lanes, each with its own
// write enable. Synchronous write, combinational read, no reset.
module dm_ram #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [DEPTH_LOG2-1:0] word_addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            // Commit this lane when the access writes it.
            always_ff @(posedge clk) begin
                if (we && be[gi]) begin
                    lane_mem[word_addr] <= wdata[gi*8 +: 8];
                end
            end

            assign rdata[gi*8 +: 8] = lane_mem[word_addr];
        end
    endgenerate

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory controller: request/ready handshake, alignment check,
// programmable wait states, byte/half/word stores and extended loads.
module dm_ctrl
    import dm_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int WAIT_CYC   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  unsigned_ld,
    input  logic [DEPTH_LOG2+1:0] addr,
    input  logic [31:0]           din,
    output logic [31:0]           dout,
    output logic                  ready,
    output logic                  busy,
    output logic                  misalign
);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

    dm_state_e             state_reg;
    logic [3:0]            cnt_reg;
    logic                  we_reg;
    logic [1:0]            size_reg;
    logic                  uns_reg;
    logic [DEPTH_LOG2+1:0] addr_reg;
    logic [31:0]           din_reg;
    logic [31:0]           dout_reg;
    logic                  ready_reg;
    logic                  misalign_reg;

    logic                  access_edge;
    logic                  ram_we;
    logic [3:0]            ram_be;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;
    logic                  req_err;

    // Alignment check on the live inputs so the accept edge can branch.
    assign req_err = dm_misaligned(size, addr[1:0]);

    // The access happens on the edge where the wait counter has run out.
    assign access_edge = (state_reg == ST_ACCESS) && (cnt_reg == 4'd0);
    assign ram_we      = access_edge && we_reg;
    assign ram_be      = dm_byte_en(size_reg, addr_reg[1:0]);
    assign ram_wdata   = dm_store_data(size_reg, din_reg);

    dm_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk       (clk),
        .we        (ram_we),
        .be        (ram_be),
        .word_addr (addr_reg[DEPTH_LOG2+1:2]),
        .wdata     (ram_wdata),
        .rdata     (ram_rdata)
    );

    // Main FSM: accept, wait out the programmed cycles, access, respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 4'd0;
            we_reg       <= 1'b0;
            size_reg     <= SZ_B;
            uns_reg      <= 1'b0;
            addr_reg     <= '0;
            din_reg      <= 32'd0;
            dout_reg     <= 32'd0;
            ready_reg    <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    ready_reg <= 1'b0;
                    if (req) begin
                        we_reg   <= we;
                        size_reg <= size;
                        uns_reg  <= unsigned_ld;
                        addr_reg <= addr;
                        din_reg  <= din;
                        if (req_err) begin
                            // Rejected access: answer straight away, no array traffic.
                            misalign_reg <= 1'b1;
                            dout_reg     <= 32'd0;
                            ready_reg    <= 1'b1;
                            state_reg    <= ST_RESP;
                        end else begin
                            misalign_reg <= 1'b0;
                            cnt_reg      <= WAIT_INIT;
                            state_reg    <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        // Stores commit in the RAM this edge; loads capture here.
                        if (!we_reg) begin
                            dout_reg <= dm_load_extend(size_reg, addr_reg[1:0], uns_reg, ram_rdata);
                        end
                        ready_reg <= 1'b1;
                        state_reg <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // One-cycle response; req is deliberately not looked at here.
                    ready_reg    <= 1'b0;
                    misalign_reg <= 1'b0;
                    state_reg    <= ST_IDLE;
                end
                default: begin
                    ready_reg    <= 1'b0;
                    misalign_reg <= 1'b0;
                    state_reg    <= ST_IDLE;
                end
            endcase
        end
    end

    assign dout     = dout_reg;
    assign ready    = ready_reg;
    assign misalign = misalign_reg;
    assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_dm_ctrl.sv
// Scoreboard bench for dm_ctrl: one instance with no wait states and the
// default depth, one with three wait states and a 16-word array.
module tb_dm_ctrl;
    import dm_pkg::*;

    typedef struct {
        logic [31:0] d;
        logic        m;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n0, rst_n1;
    logic        req0, req1;
    logic        we;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [11:0] addr;
    logic [31:0] din;

    logic [31:0] dout0, dout1;
    logic        rdy0, rdy1, bsy0, bsy1, mis0, mis1;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] last_d[2];

    dm_ctrl #(.DEPTH_LOG2(10), .WAIT_CYC(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n0), .req(req0), .we(we), .size(size),
        .unsigned_ld(unsigned_ld), .addr(addr), .din(din),
        .dout(dout0), .ready(rdy0), .busy(bsy0), .misalign(mis0)
    );

    dm_ctrl #(.DEPTH_LOG2(4), .WAIT_CYC(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n1), .req(req1), .we(we), .size(size),
        .unsigned_ld(unsigned_ld), .addr(addr[5:0]), .din(din),
        .dout(dout1), .ready(rdy1), .busy(bsy1), .misalign(mis1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitors: pop and compare whenever an instance presents ready.
    always @(negedge clk) begin
        if (rst_n0 === 1'b1 && rdy0 === 1'b1) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut0_unexpected_ready: got ready=1 at cyc %0d expected no response", cyc);
            end else begin
                exp_t e;
                e = q0.pop_front();
                $display("dut0 txn cyc=%0d dout=%h misalign=%b", cyc, dout0, mis0);
                chk("dut0_dout", dout0, e.d);
                chk("dut0_misalign", {31'd0, mis0}, {31'd0, e.m});
                chk("dut0_latency", cyc, e.c);
            end
        end
        if (rst_n1 === 1'b1 && rdy1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1_unexpected_ready: got ready=1 at cyc %0d expected no response", cyc);
            end else begin
                exp_t e;
                e = q1.pop_front();
                $display("dut1 txn cyc=%0d dout=%h misalign=%b", cyc, dout1, mis1);
                chk("dut1_dout", dout1, e.d);
                chk("dut1_misalign", {31'd0, mis1}, {31'd0, e.m});
                chk("dut1_latency", cyc, e.c);
            end
        end
    end

    // Present one request for a single cycle and queue its expected response.
    task automatic start_txn(input int inst, input logic w, input logic [1:0] sz,
                             input logic u, input logic [11:0] a, input logic [31:0] d,
                             input logic [31:0] exp_load, input logic exp_err);
        exp_t e;
        int   wc;
        for (int i = 0; i < 50 && (inst == 0 ? bsy0 : bsy1); i++) begin
            @(posedge clk); #1;
        end
        we = w; size = sz; unsigned_ld = u; addr = a; din = d;
        if (inst == 0) req0 = 1'b1; else req1 = 1'b1;
        wc  = (inst == 0) ? 0 : 3;
        e.m = exp_err;
        e.d = exp_err ? 32'd0 : (w ? last_d[inst] : exp_load);
        e.c = exp_err ? cyc + 1 : cyc + wc + 2;
        last_d[inst] = e.d;
        if (inst == 0) q0.push_back(e); else q1.push_back(e);
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
    endtask

    // Bounded wait for the scoreboard queue of one instance to drain.
    task automatic wait_done(input int inst);
        for (int i = 0; i < 40 && ((inst == 0) ? q0.size() : q1.size()) != 0; i++) begin
            @(posedge clk); #1;
        end
        if (((inst == 0) ? q0.size() : q1.size()) != 0) begin
            checks++; errors++;
            $display("FAIL dut%0d_timeout: got no ready expected a response within 40 cycles", inst);
            if (inst == 0) q0.delete(); else q1.delete();
        end
    endtask

    task automatic run(input int inst, input logic w, input logic [1:0] sz, input logic u,
                       input logic [11:0] a, input logic [31:0] d,
                       input logic [31:0] exp_load, input logic exp_err);
        start_txn(inst, w, sz, u, a, d, exp_load, exp_err);
        wait_done(inst);
    endtask

    initial begin
        rst_n0 = 1'b0; rst_n1 = 1'b0; req0 = 1'b0; req1 = 1'b0;
        we = 1'b0; size = SZ_W; unsigned_ld = 1'b0; addr = '0; din = '0;
        last_d[0] = 32'd0; last_d[1] = 32'd0;
        #1;
        chk("reset_outputs_dut0", {dout0[30:0], rdy0}, 32'd0);
        chk("reset_outputs_dut1", {dout1[30:0], rdy1}, 32'd0);
        chk("reset_flags", {28'd0, bsy0, mis0, bsy1, mis1}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n0 = 1'b1; rst_n1 = 1'b1;
        @(posedge clk); #1;

        // ---- no wait states ----
        run(0, 1, SZ_W, 0, 12'h010, 32'h1234_5678, 32'd0, 0);
        run(0, 0, SZ_W, 0, 12'h010, 32'd0, 32'h1234_5678, 0);
        run(0, 1, SZ_W, 0, 12'h010, 32'h0000_0000, 32'd0, 0);
        run(0, 1, SZ_B, 0, 12'h013, 32'h5555_55AB, 32'd0, 0);
        run(0, 0, SZ_W, 0, 12'h010, 32'd0, 32'hAB00_0000, 0);
        run(0, 0, SZ_B, 0, 12'h013, 32'd0, 32'hFFFF_FFAB, 0);
        run(0, 0, SZ_B, 1, 12'h013, 32'd0, 32'h0000_00AB, 0);
        run(0, 1, SZ_H, 0, 12'h012, 32'h7777_8001, 32'd0, 0);
        run(0, 0, SZ_H, 0, 12'h012, 32'd0, 32'hFFFF_8001, 0);
        run(0, 0, SZ_H, 1, 12'h012, 32'd0, 32'h0000_8001, 0);
        run(0, 0, SZ_W, 0, 12'h010, 32'd0, 32'h8001_0000, 0);
        run(0, 1, SZ_B, 0, 12'h011, 32'h0000_0042, 32'd0, 0);
        run(0, 0, SZ_H, 0, 12'h010, 32'd0, 32'h0000_4200, 0);
        // error responses leave the array alone
        run(0, 1, SZ_W, 0, 12'h000, 32'hCAFE_F00D, 32'd0, 0);
        run(0, 0, SZ_H, 0, 12'h011, 32'd0, 32'd0, 1);
        run(0, 1, SZ_W, 0, 12'h002, 32'hFFFF_FFFF, 32'd0, 1);
        run(0, 0, SZ_X, 0, 12'h000, 32'd0, 32'd0, 1);
        run(0, 1, SZ_H, 0, 12'h001, 32'h0000_1111, 32'd0, 1);
        run(0, 1, SZ_X, 0, 12'h000, 32'h2222_2222, 32'd0, 1);
        run(0, 0, SZ_W, 0, 12'h000, 32'd0, 32'hCAFE_F00D, 0);

        // ---- three wait states, 16-word array ----
        run(1, 1, SZ_W, 0, 12'h000, 32'hAAAA_5555, 32'd0, 0);
        run(1, 1, SZ_W, 0, 12'h03C, 32'h1122_3344, 32'd0, 0);
        start_txn(1, 0, SZ_W, 0, 12'h03C, 32'd0, 32'h1122_3344, 0);
        chk("busy_at_accept", {31'd0, bsy1}, 32'd1);
        chk("no_ready_at_accept", {31'd0, rdy1}, 32'd0);
        // A request while busy must not start a second access.
        we = 1'b1; size = SZ_W; addr = 12'h000; din = 32'hBAD0_BAD0; req1 = 1'b1;
        @(posedge clk); #1;
        req1 = 1'b0;
        wait_done(1);
        repeat (8) @(posedge clk);
        #1;
        chk("busy_after_resp", {31'd0, bsy1}, 32'd0);
        run(1, 0, SZ_W, 0, 12'h000, 32'd0, 32'hAAAA_5555, 0);
        run(1, 0, SZ_B, 0, 12'h03E, 32'd0, 32'h0000_0022, 0);
        run(1, 0, SZ_W, 0, 12'h001, 32'd0, 32'd0, 1);

        // Reset in the middle of a store drops it.
        run(1, 1, SZ_W, 0, 12'h020, 32'h0000_0000, 32'd0, 0);
        run(1, 0, SZ_W, 0, 12'h000, 32'd0, 32'hAAAA_5555, 0);
        @(posedge clk); #1;
        we = 1'b1; size = SZ_W; unsigned_ld = 1'b0; addr = 12'h020; din = 32'hDEAD_BEEF;
        req1 = 1'b1;
        @(posedge clk); #1;
        req1 = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n1 = 1'b0;
        #1;
        chk("reset_mid_dout", dout1, 32'd0);
        chk("reset_mid_flags", {29'd0, rdy1, bsy1, mis1}, 32'd0);
        last_d[1] = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n1 = 1'b1;
        @(posedge clk); #1;
        run(1, 0, SZ_W, 0, 12'h020, 32'd0, 32'h0000_0000, 0);
        run(1, 0, SZ_W, 0, 12'h03C, 32'd0, 32'h1122_3344, 0);

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
